// File: rtl/pomdp_pkg.sv
// Shared sizes, FSM encoding and LFSR taps for the tiger-problem POMDP simulator.
package pomdp_pkg;

  localparam int N_STATE = 2;
  localparam int N_ACT   = 3;
  localparam int N_OBS   = 2;
  localparam int N_ALPHA = 16;
  localparam int PW      = 16;
  localparam int RW      = 32;

  // x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [PW-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECIDE,
    ST_ACT,
    ST_OBSV,
    ST_UPD,
    ST_NORM
  } state_e;

  // A probability of FFFF is treated as exactly 1.0 so the event is certain.
  function automatic logic [PW:0] prob_thresh(input logic [PW-1:0] p);
    return (p == 16'hFFFF) ? 17'h10000 : {1'b0, p};
  endfunction

endpackage

// File: rtl/pomdp_sim_if.sv
// Run-control and status bundle between a driver (master) and the simulator (slave).
interface pomdp_sim_if;
  import pomdp_pkg::*;

  logic          en;
  logic          initial_state;
  logic [PW-1:0] seed0;
  logic [PW-1:0] seed1;
  logic [PW-1:0] initial_belief [0:N_STATE-1];
  logic [1:0]    action;
  logic          observation;
  logic          cur_state;
  logic [RW-1:0] reward;

  modport master (
    output en, initial_state, seed0, seed1, initial_belief,
    input  action, observation, cur_state, reward
  );

  modport slave (
    input  en, initial_state, seed0, seed1, initial_belief,
    output action, observation, cur_state, reward
  );

endinterface

// File: rtl/pomdp_sim_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left with feedback into bit 0; a zero seed loads as 1.
module lfsr16
  import pomdp_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [PW-1:0] seed,
  input  logic          step,
  output logic [PW-1:0] q
);

  logic [PW-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (seed == '0) ? 16'h0001 : seed;
    end else if (step) begin
      q_d = {q_q[PW-2:0], ^(q_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pomdp_sim_top.sv
// Closed-loop PBVI tiger-problem simulator: decide, act, observe, belief update, normalise.
// Optional step trace with POMDP_SIM_TRACE_EN (simulation only).
module pomdp_sim_top
  import pomdp_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  pomdp_sim_if.slave    bus,
  input  logic [PW-1:0] alpha        [0:N_ALPHA-1][0:N_STATE-1],
  input  logic [PW-1:0] vec_reward   [0:N_ACT-1][0:N_STATE-1],
  input  logic [1:0]    point_action [0:N_ALPHA-1],
  input  logic [PW-1:0] trans        [0:N_ACT-1][0:N_STATE-1][0:N_STATE-1],
  input  logic [PW-1:0] observe      [0:N_ACT-1][0:N_STATE-1][0:N_OBS-1]
);

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [PW-1:0]   b0_q, b0_d, b1_q, b1_d;
  logic [2*PW:0]   max_q, max_d;
  logic [3:0]      best_q, best_d;
  logic [1:0]      action_q, action_d;
  logic            obs_q, obs_d;
  logic            cur_q, cur_d;
  logic            snext_q, snext_d;
  logic [RW-1:0]   reward_q, reward_d;
  logic [PW+1:0]   den_q, den_d, rem_q, rem_d;
  logic [PW:0]     dsh_q, dsh_d, quo_q, quo_d;

  logic            lfsr_load, lfsr0_step, lfsr1_step;
  logic [PW-1:0]   lfsr0_q, lfsr1_q;
  logic [2*PW:0]   dot_w;
  logic [1:0]      act_new_w;
  logic [PW:0]     p_w [0:N_STATE-1];
  logic [PW:0]     u_w [0:N_STATE-1];
  logic [PW+2:0]   rem_sh_w;
  logic            rem_ge_w;
  logic [PW:0]     quo_next_w;

  lfsr16 u_lfsr_trans (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (bus.seed0),
    .step  (lfsr0_step),
    .q     (lfsr0_q)
  );

  lfsr16 u_lfsr_obs (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (bus.seed1),
    .step  (lfsr1_step),
    .q     (lfsr1_q)
  );

  assign dot_w = 33'(alpha[cnt_q[3:0]][0]) * 33'(b0_q)
               + 33'(alpha[cnt_q[3:0]][1]) * 33'(b1_q);
  assign act_new_w = point_action[best_q];

  // Predicted belief p[j] and observation-weighted u[j] for the action just taken.
  for (genvar gi = 0; gi < N_STATE; gi++) begin : g_upd
    assign p_w[gi] = 17'((33'(trans[action_q][0][gi]) * 33'(b0_q)
                        + 33'(trans[action_q][1][gi]) * 33'(b1_q)) >> 16);
    assign u_w[gi] = 17'((33'(observe[action_q][gi][obs_q]) * 33'(p_w[gi])) >> 16);
  end

  // Restoring divider: remainder starts at (u0<<16)>>17, so 17 steps give the full quotient.
  assign rem_sh_w   = {rem_q, dsh_q[PW]};
  assign rem_ge_w   = (rem_sh_w >= {1'b0, den_q});
  assign quo_next_w = {quo_q[PW-1:0], rem_ge_w};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    max_d      = max_q;
    best_d     = best_q;
    action_d   = action_q;
    obs_d      = obs_q;
    cur_d      = cur_q;
    snext_d    = snext_q;
    reward_d   = reward_q;
    den_d      = den_q;
    rem_d      = rem_q;
    dsh_d      = dsh_q;
    quo_d      = quo_q;
    lfsr_load  = 1'b0;
    lfsr0_step = 1'b0;
    lfsr1_step = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          b0_d      = bus.initial_belief[0];
          b1_d      = bus.initial_belief[1];
          cur_d     = bus.initial_state;
          reward_d  = '0;
          max_d     = '0;
          best_d    = '0;
          cnt_d     = '0;
          lfsr_load = 1'b1;
          state_d   = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        if (cnt_q == 5'd0 || dot_w > max_q) begin
          max_d  = dot_w;
          best_d = cnt_q[3:0];
        end
        if (cnt_q == 5'd15) begin
          cnt_d   = '0;
          state_d = ST_ACT;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_ACT: begin
        action_d   = act_new_w;
        reward_d   = reward_q + 32'(vec_reward[act_new_w][cur_q]);
        snext_d    = ({1'b0, lfsr0_q} < prob_thresh(trans[act_new_w][cur_q][0])) ? 1'b0 : 1'b1;
        lfsr0_step = 1'b1;
        state_d    = ST_OBSV;
      end
      ST_OBSV: begin
        obs_d      = ({1'b0, lfsr1_q} < prob_thresh(observe[action_q][snext_q][0])) ? 1'b0 : 1'b1;
        cur_d      = snext_q;
        lfsr1_step = 1'b1;
        state_d    = ST_UPD;
      end
      ST_UPD: begin
        den_d   = 18'(u_w[0]) + 18'(u_w[1]);
        rem_d   = 18'(u_w[0][PW:1]);
        dsh_d   = {u_w[0][0], 16'h0000};
        quo_d   = '0;
        cnt_d   = '0;
        state_d = ST_NORM;
      end
      ST_NORM: begin
        rem_d = rem_ge_w ? 18'(rem_sh_w - {1'b0, den_q}) : rem_sh_w[PW+1:0];
        dsh_d = {dsh_q[PW-1:0], 1'b0};
        quo_d = quo_next_w;
        if (cnt_q == 5'd16) begin
          if (den_q != '0) begin
            b0_d = quo_next_w[PW] ? 16'hFFFF : quo_next_w[PW-1:0];
            b1_d = 16'hFFFF - b0_d;
          end
          cnt_d   = '0;
          state_d = ST_DECIDE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      max_q    <= '0;
      best_q   <= '0;
      action_q <= '0;
      obs_q    <= 1'b0;
      cur_q    <= 1'b0;
      snext_q  <= 1'b0;
      reward_q <= '0;
      den_q    <= '0;
      rem_q    <= '0;
      dsh_q    <= '0;
      quo_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      max_q    <= max_d;
      best_q   <= best_d;
      action_q <= action_d;
      obs_q    <= obs_d;
      cur_q    <= cur_d;
      snext_q  <= snext_d;
      reward_q <= reward_d;
      den_q    <= den_d;
      rem_q    <= rem_d;
      dsh_q    <= dsh_d;
      quo_q    <= quo_d;
    end
  end

  assign bus.action      = action_q;
  assign bus.observation = obs_q;
  assign bus.cur_state   = cur_q;
  assign bus.reward      = reward_q;

`ifdef POMDP_SIM_TRACE_EN
  logic [31:0] trace_step_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trace_step_q <= '0;
    end else if (state_q == ST_OBSV) begin
      trace_step_q <= trace_step_q + 32'd1;
      $display("pomdp step %0d: action=%0d observation=%0d cur_state=%0d reward=%0d",
               trace_step_q, action_q, obs_d, cur_d, reward_q);
    end
  end
`endif

endmodule

// File: tb/tb_pomdp_sim_top.sv
// Directed bench for pomdp_sim_top: tiger model, hand-computed steps plus a step model.
module tb_pomdp_sim_top;
  import pomdp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic [PW-1:0] alpha        [0:N_ALPHA-1][0:N_STATE-1];
  logic [PW-1:0] vec_reward   [0:N_ACT-1][0:N_STATE-1];
  logic [1:0]    point_action [0:N_ALPHA-1];
  logic [PW-1:0] trans        [0:N_ACT-1][0:N_STATE-1][0:N_STATE-1];
  logic [PW-1:0] observe      [0:N_ACT-1][0:N_STATE-1][0:N_OBS-1];

  int n_checks;
  int n_errors;

  // Reference model state
  logic [15:0] m_b0, m_b1, m_l0, m_l1;
  logic        m_s, m_o;
  logic [1:0]  m_a;
  logic [31:0] m_rew;

  pomdp_sim_if bus ();

  pomdp_sim_top dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alpha        (alpha),
    .vec_reward   (vec_reward),
    .point_action (point_action),
    .trans        (trans),
    .observe      (observe)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    adv(2);
    rst_n = 1'b1;
  endtask

  task automatic set_listen_obs(input logic [15:0] hit, input logic [15:0] miss);
    observe[2][0][0] = hit;
    observe[2][0][1] = miss;
    observe[2][1][0] = miss;
    observe[2][1][1] = hit;
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  function automatic longint thr(input logic [15:0] p);
    return (p == 16'hFFFF) ? 64'd65536 : longint'(p);
  endfunction

  task automatic model_init(input logic s, input logic [15:0] sd0, input logic [15:0] sd1);
    m_b0  = 16'h8000;
    m_b1  = 16'h8000;
    m_s   = s;
    m_l0  = (sd0 == 16'h0) ? 16'h0001 : sd0;
    m_l1  = (sd1 == 16'h0) ? 16'h0001 : sd1;
    m_rew = 32'd0;
  endtask

  task automatic model_step();
    longint dot, best_dot, p0, p1, u0, u1, den, q;
    int     best;
    logic   sn;
    best_dot = -1;
    best     = 0;
    for (int i = 0; i < N_ALPHA; i++) begin
      dot = longint'(alpha[i][0]) * longint'(m_b0) + longint'(alpha[i][1]) * longint'(m_b1);
      if (dot > best_dot) begin
        best_dot = dot;
        best     = i;
      end
    end
    m_a   = point_action[best];
    m_rew = m_rew + 32'(vec_reward[m_a][m_s]);
    sn    = (longint'(m_l0) < thr(trans[m_a][m_s][0])) ? 1'b0 : 1'b1;
    m_l0  = lfsr_adv(m_l0);
    m_o   = (longint'(m_l1) < thr(observe[m_a][sn][0])) ? 1'b0 : 1'b1;
    m_l1  = lfsr_adv(m_l1);
    m_s   = sn;
    p0 = (longint'(trans[m_a][0][0]) * longint'(m_b0) + longint'(trans[m_a][1][0]) * longint'(m_b1)) >> 16;
    p1 = (longint'(trans[m_a][0][1]) * longint'(m_b0) + longint'(trans[m_a][1][1]) * longint'(m_b1)) >> 16;
    u0 = (longint'(observe[m_a][0][m_o]) * p0) >> 16;
    u1 = (longint'(observe[m_a][1][m_o]) * p1) >> 16;
    den = u0 + u1;
    if (den != 0) begin
      q = (u0 << 16) / den;
      if (q > 65535) q = 65535;
      m_b0 = 16'(q);
      m_b1 = 16'hFFFF - m_b0;
    end
  endtask

  task automatic compare_step(input int k);
    check($sformatf("step%0d_action", k), 32'(bus.action), 32'(m_a));
    check($sformatf("step%0d_obs", k), 32'(bus.observation), 32'(m_o));
    check($sformatf("step%0d_state", k), 32'(bus.cur_state), 32'(m_s));
    check($sformatf("step%0d_reward", k), bus.reward, m_rew);
  endtask

  task automatic load_tiger();
    alpha = '{'{16'd13464, 16'd20673}, '{16'd19082, 16'd20393}, '{16'd19216, 16'd20378},
              '{16'd19262, 16'd20366}, '{16'd19950, 16'd20102}, '{16'd19950, 16'd20102},
              '{16'd19950, 16'd20102}, '{16'd20035, 16'd20035}, '{16'd20035, 16'd20035},
              '{16'd20102, 16'd19950}, '{16'd20102, 16'd19950}, '{16'd20102, 16'd19950},
              '{16'd20366, 16'd19262}, '{16'd20378, 16'd19216}, '{16'd20393, 16'd19082},
              '{16'd20673, 16'd13464}};
    for (int i = 0; i < N_ALPHA; i++) point_action[i] = 2'd2;
    point_action[0]  = 2'd1;
    point_action[15] = 2'd0;
    vec_reward = '{'{16'd7209, 16'd0}, '{16'd0, 16'd7209}, '{16'd6488, 16'd6488}};
    for (int a = 0; a < N_ACT; a++)
      for (int s = 0; s < N_STATE; s++)
        for (int j = 0; j < N_STATE; j++) begin
          trans[a][s][j]   = (a == 2) ? ((s == j) ? 16'hFFFF : 16'h0000) : 16'h8000;
          observe[a][s][j] = 16'h8000;
        end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    load_tiger();
    set_listen_obs(16'd55706, 16'd9830);
    bus.en                = 1'b0;
    bus.initial_state     = 1'b0;
    bus.seed0             = 16'h0001;
    bus.seed1             = 16'h0001;
    bus.initial_belief[0] = 16'h8000;
    bus.initial_belief[1] = 16'h8000;

    // Reset values, then idle with no start pulse
    rst_n = 1'b0;
    adv(3);
    check("rst_action", 32'(bus.action), 32'd0);
    check("rst_obs", 32'(bus.observation), 32'd0);
    check("rst_state", 32'(bus.cur_state), 32'd0);
    check("rst_reward", bus.reward, 32'd0);
    rst_n = 1'b1;
    adv(50);
    check("idle_action", 32'(bus.action), 32'd0);
    check("idle_reward", bus.reward, 32'd0);
    check("idle_state", 32'(bus.cur_state), 32'd0);

    // First decision: alpha[7] wins the tie, listen
    start_run();
    adv(17);
    check("dec1_action", 32'(bus.action), 32'd2);
    check("dec1_reward", bus.reward, 32'd6488);
    adv(10);
    rst_n = 1'b0;
    adv(1);
    check("midrst_action", 32'(bus.action), 32'd0);
    check("midrst_reward", bus.reward, 32'd0);
    rst_n = 1'b1;
    adv(2);

    // Deterministic listen
    set_listen_obs(16'hFFFF, 16'h0000);
    start_run();
    adv(18);
    check("det1_action", 32'(bus.action), 32'd2);
    check("det1_obs", 32'(bus.observation), 32'd0);
    check("det1_state", 32'(bus.cur_state), 32'd0);
    check("det1_reward", bus.reward, 32'd6488);
    adv(35);
    check("det2_action", 32'(bus.action), 32'd0);
    check("det2_reward", bus.reward, 32'd13697);
    do_reset();

    // Noisy listen with a mid-run start pulse that must be ignored
    set_listen_obs(16'd55706, 16'd9830);
    bus.seed0 = 16'hA24B;
    bus.seed1 = 16'hC354;
    bus.initial_state = 1'b0;
    start_run();
    model_init(1'b0, 16'hA24B, 16'hC354);
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) begin
        adv(18);
      end else if (k == 5) begin
        @(negedge clk);
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        adv(35);
      end else begin
        adv(36);
      end
      model_step();
      compare_step(k);
      if (k == 1) check("noisy1_obs", 32'(bus.observation), 32'd0);
      if (k == 2) check("noisy2_obs", 32'(bus.observation), 32'd0);
      if (k == 3) begin
        check("noisy3_action", 32'(bus.action), 32'd0);
        check("noisy3_reward", bus.reward, 32'd20185);
      end
    end
    do_reset();

    // Certainty: always listen from state 1, zero observation seed
    for (int i = 0; i < N_ALPHA; i++) point_action[i] = 2'd2;
    bus.seed0 = 16'h1234;
    bus.seed1 = 16'h0000;
    bus.initial_state = 1'b1;
    start_run();
    model_init(1'b1, 16'h1234, 16'h0000);
    for (int k = 1; k <= 20; k++) begin
      adv((k == 1) ? 18 : 36);
      model_step();
      check($sformatf("cert%0d_state", k), 32'(bus.cur_state), 32'd1);
      check($sformatf("cert%0d_obs", k), 32'(bus.observation), 32'(m_o));
    end
    check("cert_reward", bus.reward, 32'd129760);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
